// File: rtl/ntt_pkg.sv
// Shared types, moduli and modular helpers for the NTT butterfly datapath.
// Reduction is Barrett with k = 2*ceil(log2 q), so at most two corrections are needed.
package ntt_pkg;

  localparam int unsigned COEF_W = 23;
  typedef logic [COEF_W-1:0] coef_t;

  localparam coef_t Q_KYBER        = 23'd3329;
  localparam coef_t Q_DILITHIUM    = 23'd8380417;
  localparam coef_t INV2_KYBER     = 23'd1665;
  localparam coef_t INV2_DILITHIUM = 23'd4190209;

  localparam logic [23:0] MU_KYBER     = 24'((64'd1 << 24) / 64'd3329);
  localparam logic [23:0] MU_DILITHIUM = 24'((64'd1 << 46) / 64'd8380417);

  typedef enum logic {RED_DILITHIUM = 1'b0, RED_KYBER = 1'b1} red_mode_e;
  typedef enum logic {BFLY_CT = 1'b0, BFLY_GS = 1'b1} bfly_mode_e;

  function automatic coef_t modulus(red_mode_e m);
    return (m == RED_KYBER) ? Q_KYBER : Q_DILITHIUM;
  endfunction

  function automatic coef_t mod_add(coef_t x, coef_t y, red_mode_e m);
    logic [COEF_W:0] s;
    logic [COEF_W:0] q;
    q = {1'b0, modulus(m)};
    s = {1'b0, x} + {1'b0, y};
    if (s >= q) s = s - q;
    return s[COEF_W-1:0];
  endfunction

  function automatic coef_t mod_sub(coef_t x, coef_t y, red_mode_e m);
    logic [COEF_W:0] s;
    if (x >= y) begin
      s = {1'b0, x} - {1'b0, y};
    end else begin
      s = {1'b0, x} + {1'b0, modulus(m)} - {1'b0, y};
    end
    return s[COEF_W-1:0];
  endfunction

  // v * 2^-1 mod q without a multiplier: odd values borrow one q first.
  function automatic coef_t mod_half(coef_t x, red_mode_e m);
    logic [COEF_W:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + {1'b0, modulus(m)};
    return s[COEF_W:1];
  endfunction

  function automatic coef_t barrett(logic [45:0] x, red_mode_e m);
    logic [69:0] p;
    logic [46:0] qh;
    logic [47:0] r;
    logic [47:0] q;
    q = 48'(modulus(m));
    if (m == RED_KYBER) begin
      p  = 70'(x[23:0]) * 70'(MU_KYBER);
      qh = 47'(p >> 24);
    end else begin
      p  = 70'(x) * 70'(MU_DILITHIUM);
      qh = 47'(p >> 46);
    end
    r = 48'(x) - 48'(qh) * q;
    if (r >= q) r = r - q;
    if (r >= q) r = r - q;
    return r[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Handshake/data bundle for butterfly_pipe: input side (in_*) and result side (out_*).
interface butterfly_pipe_if #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned TAG_W  = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] twiddle;
  logic              sel_red;
  logic              sel_butterfly;
  logic [TAG_W-1:0]  tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [TAG_W-1:0]  tag_out;

  modport slave (
    input  in_valid, a, b, twiddle, sel_red, sel_butterfly, tag, out_ready,
    output in_ready, out_valid, a_out, b_out, tag_out
  );

  modport master (
    output in_valid, a, b, twiddle, sel_red, sel_butterfly, tag, out_ready,
    input  in_ready, out_valid, a_out, b_out, tag_out
  );
endinterface

// File: rtl/mod_mult.sv
// Two-stage modular multiplier: registered product, then registered Barrett reduction.
// Data-only pipeline; validity is tracked by the caller, so no reset is needed here.
module mod_mult
  import ntt_pkg::*;
(
  input  logic      clk_i,
  input  logic      en_i,
  input  red_mode_e red_i,
  input  coef_t     x_i,
  input  coef_t     w_i,
  output coef_t     r_o
);

  logic [45:0] prod_q;
  red_mode_e   red_q;
  coef_t       r_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      prod_q <= 46'(x_i) * 46'(w_i);
      red_q  <= red_i;
      r_q    <= barrett(prod_q, red_q);
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage dual-modulus CT/GS butterfly with valid/ready flow control.
// Define BUTTERFLY_PIPE_DIV2_EN to halve both GS outputs (INTT scaling) in the last stage.
module butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned LAT    = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  butterfly_pipe_if.slave   bus
);

  if (LAT != 4) begin : g_lat_check
    $error("butterfly_pipe: LAT must be 4");
  end
  if (DATA_W < COEF_W) begin : g_width_check
    $error("butterfly_pipe: DATA_W must be at least 23");
  end

  logic       advance;
  logic       v1_q, v2_q, v3_q, v4_q;
  coef_t      a1_q, b1_q, w1_q, a2_q, b2_q, a3_q, b3_q, a4_q, b4_q;
  red_mode_e  red1_q, red2_q, red3_q;
  bfly_mode_e bf1_q, bf2_q, bf3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
  coef_t      mult_x, t3, a4_d, b4_d;

  // Whole pipe shifts together; only a stalled full output stage blocks it.
  assign advance     = !v4_q || bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else if (advance) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      a1_q   <= coef_t'(bus.a);
      b1_q   <= coef_t'(bus.b);
      w1_q   <= coef_t'(bus.twiddle);
      red1_q <= red_mode_e'(bus.sel_red);
      bf1_q  <= bfly_mode_e'(bus.sel_butterfly);
      tag1_q <= bus.tag;
      a2_q   <= a1_q;
      b2_q   <= b1_q;
      red2_q <= red1_q;
      bf2_q  <= bf1_q;
      tag2_q <= tag1_q;
      a3_q   <= a2_q;
      b3_q   <= b2_q;
      red3_q <= red2_q;
      bf3_q  <= bf2_q;
      tag3_q <= tag2_q;
      a4_q   <= a4_d;
      b4_q   <= b4_d;
      tag4_q <= tag3_q;
    end
  end

  // CT multiplies b by w; GS multiplies the difference (a - b) by w.
  always_comb begin
    mult_x = b1_q;
    if (bf1_q == BFLY_GS) mult_x = mod_sub(a1_q, b1_q, red1_q);
  end

  mod_mult u_mod_mult (
    .clk_i (clk_i),
    .en_i  (advance),
    .red_i (red1_q),
    .x_i   (mult_x),
    .w_i   (w1_q),
    .r_o   (t3)
  );

  always_comb begin
    a4_d = mod_add(a3_q, t3, red3_q);
    b4_d = mod_sub(a3_q, t3, red3_q);
    if (bf3_q == BFLY_GS) begin
      a4_d = mod_add(a3_q, b3_q, red3_q);
      b4_d = t3;
`ifdef BUTTERFLY_PIPE_DIV2_EN
      a4_d = mod_half(a4_d, red3_q);
      b4_d = mod_half(b4_d, red3_q);
`else
      a4_d = a4_d;
      b4_d = b4_d;
`endif
    end
  end

  // Output data registers are unreset; gating keeps the bus at zero whenever idle.
  assign bus.out_valid = v4_q;
  assign bus.a_out     = v4_q ? DATA_W'(a4_q) : '0;
  assign bus.b_out     = v4_q ? DATA_W'(b4_q) : '0;
  assign bus.tag_out   = v4_q ? tag4_q : '0;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, backpressure, reset, random soak.
module tb_butterfly_pipe;
  import ntt_pkg::*;

  localparam int unsigned DATA_W = 23;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned SOAK_N = 10000;
`ifdef BUTTERFLY_PIPE_DIV2_EN
  localparam bit DIV2 = 1'b1;
`else
  localparam bit DIV2 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  butterfly_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LAT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  longint unsigned exp_a[$];
  longint unsigned exp_b[$];
  longint unsigned exp_t[$];

  // Reference butterfly straight from the modular definitions.
  task automatic ref_bfly(input longint unsigned a, b, w, input bit kyber, gs,
                          output longint unsigned ra, rb);
    longint unsigned q, inv2, t;
    q    = kyber ? 64'd3329 : 64'd8380417;
    inv2 = kyber ? 64'd1665 : 64'd4190209;
    if (!gs) begin
      t  = (w * b) % q;
      ra = (a + t) % q;
      rb = (a + q - t) % q;
    end else begin
      ra = (a + b) % q;
      rb = (((a + q - b) % q) * w) % q;
      if (DIV2) begin
        ra = (ra * inv2) % q;
        rb = (rb * inv2) % q;
      end
    end
  endtask

  task automatic drive_in(input bit v, input longint unsigned a, b, w,
                          input bit kyber, gs, input int unsigned tag);
    bus.in_valid      = v;
    bus.a             = DATA_W'(a);
    bus.b             = DATA_W'(b);
    bus.twiddle       = DATA_W'(w);
    bus.sel_red       = kyber;
    bus.sel_butterfly = gs;
    bus.tag           = TAG_W'(tag);
  endtask

  task automatic rand_txn(output longint unsigned a, b, w, output bit kyber, gs,
                          output int unsigned tag);
    int unsigned q;
    kyber = 1'($urandom_range(1, 0));
    gs    = 1'($urandom_range(1, 0));
    q     = kyber ? 3329 : 8380417;
    a     = $urandom_range(q - 1, 0);
    b     = $urandom_range(q - 1, 0);
    w     = $urandom_range(q - 1, 0);
    tag   = $urandom_range(255, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one transaction into an empty pipe and reports latency (accept edge = 1).
  task automatic run_single(input longint unsigned a, b, w, input bit kyber, gs,
                            input int unsigned tag, output int lat,
                            output longint unsigned ra, rb, rt);
    bus.out_ready = 1'b1;
    drive_in(1'b1, a, b, w, kyber, gs, tag);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_idle: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      tick();
      lat++;
    end
    ra = bus.a_out;
    rb = bus.b_out;
    rt = bus.tag_out;
    tick();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.a_out !== '0 || bus.b_out !== '0 ||
        bus.tag_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b a=%0d b=%0d t=%0d want all 0",
               bus.out_valid, bus.a_out, bus.b_out, bus.tag_out);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_kyber_ct();
    int lat;
    longint unsigned ra, rb, rt;
    run_single(3210, 19, 281, 1'b1, 1'b0, 8'h11, lat, ra, rb, rt);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL kyber_ct_latency: got %0d want 4", lat);
    end
    n_vec++;
    if (ra !== 1891 || rb !== 1200 || rt !== 8'h11) begin
      n_err++;
      $display("FAIL kyber_ct: got a=%0d b=%0d t=%0h want a=1891 b=1200 t=11", ra, rb, rt);
    end
  endtask

  task automatic test_kyber_gs();
    int lat;
    longint unsigned ra, rb, rt, wa, wb;
    wa = DIV2 ? 64'd3210 : 64'd3091;
    wb = DIV2 ? 64'd2209 : 64'd1089;
    run_single(1891, 1200, 281, 1'b1, 1'b1, 8'h22, lat, ra, rb, rt);
    n_vec++;
    if (lat !== 4 || ra !== wa || rb !== wb || rt !== 8'h22) begin
      n_err++;
      $display("FAIL kyber_gs: got lat=%0d a=%0d b=%0d t=%0h want lat=4 a=%0d b=%0d t=22",
               lat, ra, rb, rt, wa, wb);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 8297430, 7194, 400232, 1'b0, 1'b0, 8'h01);
    tick();
    drive_in(1'b1, 3210, 19, 281, 1'b1, 1'b0, 8'h02);
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.a_out !== 4702990 || bus.b_out !== 3511453 ||
        bus.tag_out !== 8'h01) begin
      n_err++;
      $display("FAIL b2b_dilithium: got v=%b a=%0d b=%0d t=%0h want 1 4702990 3511453 01",
               bus.out_valid, bus.a_out, bus.b_out, bus.tag_out);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.a_out !== 1891 || bus.b_out !== 1200 ||
        bus.tag_out !== 8'h02) begin
      n_err++;
      $display("FAIL b2b_kyber: got v=%b a=%0d b=%0d t=%0h want 1 1891 1200 02",
               bus.out_valid, bus.a_out, bus.b_out, bus.tag_out);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    longint unsigned a, b, w, ra, rb;
    bit kyber, gs;
    int unsigned tag;
    int sent, got, stall_seen;
    sent = 0;
    got = 0;
    stall_seen = 0;
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    rand_txn(a, b, w, kyber, gs, tag);
    for (int cyc = 0; got < 6 && cyc < 80; cyc++) begin
      if (sent < 6) drive_in(1'b1, a, b, w, kyber, gs, cyc);
      else bus.in_valid = 1'b0;
      bus.out_ready = !(cyc >= 6 && cyc < 11);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall_seen++;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_in_ready: got %b want 0 at cyc %0d", bus.in_ready, cyc);
        end
      end
      if (bus.out_valid) begin
        n_vec++;
        if (exp_a.size() == 0 || bus.a_out !== exp_a[0] || bus.b_out !== exp_b[0] ||
            bus.tag_out !== exp_t[0]) begin
          n_err++;
          $display("FAIL bp_data: got a=%0d b=%0d t=%0h want a=%0d b=%0d t=%0h",
                   bus.a_out, bus.b_out, bus.tag_out,
                   exp_a.size() ? exp_a[0] : 0, exp_b.size() ? exp_b[0] : 0,
                   exp_t.size() ? exp_t[0] : 0);
        end
        if (bus.out_ready && exp_a.size() != 0) begin
          void'(exp_a.pop_front()); void'(exp_b.pop_front()); void'(exp_t.pop_front());
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        ref_bfly(a, b, w, kyber, gs, ra, rb);
        exp_a.push_back(ra); exp_b.push_back(rb); exp_t.push_back(cyc & 255);
        sent++;
        rand_txn(a, b, w, kyber, gs, tag);
      end
      tick();
    end
    n_vec++;
    if (got != 6 || stall_seen != 5) begin
      n_err++;
      $display("FAIL bp_complete: got %0d results %0d stall cycles want 6 and 5",
               got, stall_seen);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    longint unsigned a, b, w, ra, rb, rt, wa, wb;
    bit kyber, gs;
    int unsigned tag;
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_txn(a, b, w, kyber, gs, tag);
      drive_in(1'b1, a, b, w, kyber, gs, tag);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got out_valid=%b want 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.a_out !== '0 || bus.b_out !== '0 ||
        bus.tag_out !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async: got v=%b a=%0d b=%0d t=%0h want all 0",
               bus.out_valid, bus.a_out, bus.b_out, bus.tag_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    rand_txn(a, b, w, kyber, gs, tag);
    ref_bfly(a, b, w, kyber, gs, wa, wb);
    run_single(a, b, w, kyber, gs, tag, lat, ra, rb, rt);
    n_vec++;
    if (lat !== 4 || ra !== wa || rb !== wb || rt !== tag) begin
      n_err++;
      $display("FAIL rst_mid_first: got lat=%0d a=%0d b=%0d t=%0h want 4 %0d %0d %0h",
               lat, ra, rb, rt, wa, wb, tag);
    end
  endtask

  task automatic test_random_soak();
    longint unsigned a, b, w, ra, rb;
    bit kyber, gs;
    int unsigned tag;
    int sent, got;
    sent = 0;
    got = 0;
    exp_a.delete(); exp_b.delete(); exp_t.delete();
    for (int cyc = 0; got < SOAK_N && cyc < 60000; cyc++) begin
      rand_txn(a, b, w, kyber, gs, tag);
      drive_in(sent < SOAK_N && $urandom_range(3, 0) != 0, a, b, w, kyber, gs, tag);
      bus.out_ready = $urandom_range(3, 0) != 0;
      #1;
      n_vec++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        n_err++;
        $display("FAIL soak_in_ready: got %b with out_valid=%b out_ready=%b",
                 bus.in_ready, bus.out_valid, bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL soak_extra: got unexpected output a=%0d want none", bus.a_out);
        end else begin
          if (bus.a_out !== exp_a[0] || bus.b_out !== exp_b[0] ||
              bus.tag_out !== exp_t[0]) begin
            n_err++;
            if (n_err < 30)
              $display("FAIL soak_data: got a=%0d b=%0d t=%0h want a=%0d b=%0d t=%0h",
                       bus.a_out, bus.b_out, bus.tag_out, exp_a[0], exp_b[0], exp_t[0]);
          end
          void'(exp_a.pop_front()); void'(exp_b.pop_front()); void'(exp_t.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        ref_bfly(a, b, w, kyber, gs, ra, rb);
        exp_a.push_back(ra); exp_b.push_back(rb); exp_t.push_back(tag);
        sent++;
      end
      tick();
    end
    n_vec++;
    if (got != SOAK_N) begin
      n_err++;
      $display("FAIL soak_count: got %0d results want %0d", got, SOAK_N);
    end
  endtask

  initial begin
    test_reset();
    test_kyber_ct();
    test_kyber_gs();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
